// File: rtl/front_dispatch_queue.sv
// front_dispatch_queue: group FIFO from rename to dispatch with round-robin EU assignment at enqueue (ports: clk, reset_n, flush_i, rename_* in, instr_dispatch_* out, dispatched_instr_alloc_euidx_o)
package pkg_dtypes;
  localparam int LOG2_NUM_EXEC_UNITS = 2;
  typedef logic [31:0] type_iqueue_entry;
endpackage

module front_dispatch_queue
  import pkg_dtypes::*;
#(
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter int NUM_EXEC_UNITS = 4,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush_i,
  input  type_iqueue_entry               rename_instr_i [NUM_PARALLEL_INSTR_DISPATCHES],
  input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0] rename_instr_valid_i,
  output logic                           rename_ready_o,
  output type_iqueue_entry               instr_dispatch_o [NUM_PARALLEL_INSTR_DISPATCHES],
  output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0] instr_dispatch_valid_o,
  output logic [LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_o [NUM_PARALLEL_INSTR_DISPATCHES],
  input  logic                           instr_dispatch_ready_i
);
  localparam int N = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = LOG2_NUM_EXEC_UNITS;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  type_iqueue_entry mem_instr [DEPTH][N];
  logic [EW-1:0] mem_eu [DEPTH][N];
  logic [N-1:0] mem_valid [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [EW-1:0] eu_ptr, eu_acc;
  logic [EW-1:0] lane_eu [N];
  logic head_valid, enq, deq;
  assign head_valid = count != '0;
  assign rename_ready_o = count != FULL;
  assign enq = rename_ready_o && |rename_instr_valid_i && !flush_i;
  assign deq = head_valid && instr_dispatch_ready_i && !flush_i;
  always_comb begin
    eu_acc = eu_ptr;
    for (int j = 0; j < N; j++) begin
      lane_eu[j] = rename_instr_valid_i[j] ? eu_acc : '0;
      eu_acc = EW'((int'(eu_acc) + int'(rename_instr_valid_i[j])) % NUM_EXEC_UNITS);
    end
  end
  always_comb begin
    instr_dispatch_valid_o = head_valid ? mem_valid[rd_ptr] : '0;
    for (int j = 0; j < N; j++) begin
      instr_dispatch_o[j] = head_valid ? mem_instr[rd_ptr][j] : '0;
      dispatched_instr_alloc_euidx_o[j] = head_valid ? mem_eu[rd_ptr][j] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr[wr_ptr] <= rename_instr_i;
      mem_eu[wr_ptr] <= lane_eu;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      eu_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem_valid[i] <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        mem_valid[wr_ptr] <= rename_instr_valid_i;
        wr_ptr <= wr_ptr + AW'(1);
        eu_ptr <= eu_acc;
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
endmodule

// File: tb/tb_front_dispatch_queue.sv
// tb_front_dispatch_queue: randomized scoreboard bench for front_dispatch_queue
module tb_front_dispatch_queue;
  import pkg_dtypes::*;
  localparam int N = 4;
  localparam int NE = 4;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] d [N];
    logic [N-1:0] v;
    logic [LOG2_NUM_EXEC_UNITS-1:0] e [N];
  } grp_t;
  logic clk = 0;
  logic reset_n = 0;
  logic flush_i = 0;
  type_iqueue_entry rin [N];
  logic [N-1:0] vin = '0;
  logic rename_ready_o;
  type_iqueue_entry dout [N];
  logic [N-1:0] vout;
  logic [LOG2_NUM_EXEC_UNITS-1:0] euout [N];
  logic ready_i = 0;
  grp_t sb [$];
  grp_t pend_e;
  bit pend = 0;
  bit chk_en = 0;
  int eu_m = 0;
  int tests = 0;
  int fails = 0;

  front_dispatch_queue #(.NUM_PARALLEL_INSTR_DISPATCHES(N), .NUM_EXEC_UNITS(NE), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(flush_i),
    .rename_instr_i(rin),
    .rename_instr_valid_i(vin),
    .rename_ready_o(rename_ready_o),
    .instr_dispatch_o(dout),
    .instr_dispatch_valid_o(vout),
    .dispatched_instr_alloc_euidx_o(euout),
    .instr_dispatch_ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs reflect state after the last edge; inputs now decide the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rename_ready", 32'(rename_ready_o), 32'(sb.size() != DEPTH));
      if (sb.size() != 0) begin
        chk("head_valid", 32'(vout), 32'(sb[0].v));
        for (int j = 0; j < N; j++) begin
          chk($sformatf("head_data%0d", j), dout[j], sb[0].d[j]);
          chk($sformatf("head_eu%0d", j), 32'(euout[j]), 32'(sb[0].e[j]));
        end
      end else begin
        chk("empty_valid", 32'(vout), 32'd0);
        for (int j = 0; j < N; j++) begin
          chk($sformatf("empty_data%0d", j), dout[j], 32'd0);
          chk($sformatf("empty_eu%0d", j), 32'(euout[j]), 32'd0);
        end
      end
      if (reset_n && flush_i) sb.delete();
      else if (reset_n && ready_i && sb.size() != 0) void'(sb.pop_front());
    end
  end

  task automatic step(input logic [N-1:0] v, input bit f, input bit r, input bit rn = 1);
    int k;
    @(posedge clk);
    #1;
    if (pend) begin
      sb.push_back(pend_e);
      pend = 0;
    end
    if (!reset_n) begin
      sb.delete();
      eu_m = 0;
      pend = 0;
    end
    chk_en = 1;
    reset_n = rn;
    flush_i = f;
    ready_i = r;
    vin = v;
    for (int j = 0; j < N; j++) rin[j] = $urandom;
    if (rn && !f && |v && sb.size() != DEPTH) begin
      k = 0;
      pend_e.v = v;
      for (int j = 0; j < N; j++) begin
        pend_e.d[j] = rin[j];
        pend_e.e[j] = v[j] ? LOG2_NUM_EXEC_UNITS'((eu_m + k) % NE) : '0;
        if (v[j]) k++;
      end
      eu_m = (eu_m + k) % NE;
      pend = 1;
    end
  endtask

  function automatic logic [N-1:0] nz();
    return N'($urandom_range(1, (1 << N) - 1));
  endfunction

  initial begin
    for (int j = 0; j < N; j++) rin[j] = '0;
    step('0, 0, 0, 0);
    step(4'b1111, 0, 0);
    step('0, 0, 1);
    step(4'b1010, 0, 1);
    step(4'b0111, 0, 1);
    step('0, 0, 1);
    step('0, 0, 1);
    repeat (4) step(nz(), 0, 0);
    step(4'b1111, 0, 1);
    step('0, 0, 0);
    repeat (4) step('0, 0, 1);
    repeat (10) step(nz(), 0, 1);
    repeat (3) step('0, 0, 1);
    repeat (3) step(nz(), 0, 0);
    step(4'b1111, 1, 1);
    step(4'b0101, 0, 0);
    step('0, 0, 1);
    step('0, 0, 1);
    repeat (2) step(nz(), 0, 0);
    step(nz(), 0, 1, 0);
    step(4'b1001, 0, 0);
    step('0, 0, 1);
    step('0, 0, 1);
    repeat (400) step(N'($urandom), ($urandom % 20) == 0, ($urandom % 3) != 0, ($urandom % 60) != 0);
    repeat (6) step('0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
